// File: rtl/mkio_tx_encoder.sv
// -----------------------------------------------------------------------------
// mkio_tx_encoder
//
// Transmit stage of an MKIO (GOST R 52070 / MIL-STD-1553) remote terminal.
// It takes words from the subaddress device blocks over the
// tx_data / tx_cd / tx_ready handshake. Each word is sent as a bipolar
// Manchester-II line signal:
//   - a 3-bit-time sync pattern,
//   - 16 data bits, MSB first,
//   - one odd-parity bit.
// A one-word holding register lets a status word be followed by data words
// with no gap on the line.
//
// Parameters
//   HALF_BIT_CLKS : clk cycles per Manchester half-bit (legal range 2..255)
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   tx_data    in   [15:0] word to send, sampled on the accepted request edge
//   tx_cd      in   sync select: 0 = command/status sync, 1 = data sync
//   tx_ready   in   word request; only its rising edge is significant
//   tx_inhibit in   transmitter inhibit: abort and silence the line
//   do_p       out  bus driver, positive leg
//   do_n       out  bus driver, negative leg
//   tx_busy    out  a word is on the line or pending
//   tx_done    out  one-cycle pulse at the end of each completed word
//   tx_overrun out  one-cycle pulse when a request is dropped
// -----------------------------------------------------------------------------
module mkio_tx_encoder #(
  parameter int unsigned HALF_BIT_CLKS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  input  logic        tx_inhibit,
  output logic        do_p,
  output logic        do_n,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_overrun
);

  localparam logic [7:0] HB_LAST = 8'(HALF_BIT_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } state_t;

  // Odd parity over the data word: data plus parity holds an odd count of ones.
  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

  // Request edge detect
  logic        tx_ready_q_r;

  // Sequencing state
  state_t      state_r;
  logic [7:0]  timer_r;     // clocks within the current half-bit
  logic        phase_r;     // 0 = first half of a bit, 1 = second half
  logic [2:0]  hb_cnt_r;    // half-bit count within the sync field
  logic [3:0]  bit_idx_r;   // data bit being sent, 15 down to 0

  // Transmit register
  logic [15:0] tx_word_r;
  logic        tx_cd_r;
  logic        tx_par_r;

  // Holding register
  logic [15:0] hold_data_r;
  logic        hold_cd_r;
  logic        hold_par_r;
  logic        hold_full_r;

  // Internal events, delayed one clock into the output registers so that
  // they line up with the registered line drive.
  logic        done_ev_r;
  logic        ovr_ev_r;

  // Registered outputs
  logic        do_p_r;
  logic        do_n_r;
  logic        busy_r;
  logic        done_r;
  logic        ovr_r;

  // Combinational decode
  logic        req_s;
  logic        wrap_s;
  logic        active_s;
  logic        final_s;
  logic        level_s;
  logic        to_hold_s;
  logic        drop_s;

  // Decode the request, the half-bit timing and the line level of the
  // current half-bit.
  always_comb begin
    req_s     = tx_ready & ~tx_ready_q_r;
    wrap_s    = (timer_r == HB_LAST);
    active_s  = (state_r != ST_IDLE);
    final_s   = 1'b0;
    level_s   = 1'b0;
    to_hold_s = 1'b0;
    drop_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        level_s = 1'b0;
      end
      ST_SYNC: begin
        // Command/status sync is high then low; data sync is the inverse.
        level_s = (hb_cnt_r < 3'd3) ^ tx_cd_r;
      end
      ST_DATA: begin
        // A one is high-then-low, a zero is low-then-high.
        level_s = tx_word_r[bit_idx_r] ^ phase_r;
      end
      ST_PARITY: begin
        level_s = tx_par_r ^ phase_r;
        final_s = wrap_s & phase_r;
      end
      default: begin
        level_s = 1'b0;
      end
    endcase

    // On the final parity clock, a request with the holding register empty
    // is loaded straight into the transmit register. That is the same word
    // order as passing it through the holding register.
    if (req_s && active_s) begin
      if (hold_full_r) begin
        drop_s = 1'b1;
      end else begin
        to_hold_s = ~final_s;
      end
    end else begin
      drop_s    = 1'b0;
      to_hold_s = 1'b0;
    end
  end

  // Word sequencer, holding register and registered line/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ready_q_r <= 1'b0;
      state_r      <= ST_IDLE;
      timer_r      <= 8'd0;
      phase_r      <= 1'b0;
      hb_cnt_r     <= 3'd0;
      bit_idx_r    <= 4'd15;
      tx_word_r    <= 16'd0;
      tx_cd_r      <= 1'b0;
      tx_par_r     <= 1'b0;
      hold_data_r  <= 16'd0;
      hold_cd_r    <= 1'b0;
      hold_par_r   <= 1'b0;
      hold_full_r  <= 1'b0;
      done_ev_r    <= 1'b0;
      ovr_ev_r     <= 1'b0;
      do_p_r       <= 1'b0;
      do_n_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ovr_r        <= 1'b0;
    end else begin
      tx_ready_q_r <= tx_ready;

      if (tx_inhibit) begin
        // Abort: silence the line, forget every word, report nothing.
        state_r     <= ST_IDLE;
        timer_r     <= 8'd0;
        phase_r     <= 1'b0;
        hb_cnt_r    <= 3'd0;
        bit_idx_r   <= 4'd15;
        hold_full_r <= 1'b0;
        done_ev_r   <= 1'b0;
        ovr_ev_r    <= 1'b0;
        do_p_r      <= 1'b0;
        do_n_r      <= 1'b0;
        busy_r      <= 1'b0;
        done_r      <= 1'b0;
        ovr_r       <= 1'b0;
      end else begin
        do_p_r    <= active_s & level_s;
        do_n_r    <= active_s & ~level_s;
        busy_r    <= active_s | hold_full_r;
        done_r    <= done_ev_r;
        ovr_r     <= ovr_ev_r;
        done_ev_r <= final_s;
        ovr_ev_r  <= drop_s;

        if (active_s) begin
          timer_r <= wrap_s ? 8'd0 : timer_r + 8'd1;
          if (wrap_s) begin
            phase_r <= ~phase_r;
          end
        end

        case (state_r)
          ST_IDLE: begin
            if (req_s) begin
              tx_word_r <= tx_data;
              tx_cd_r   <= tx_cd;
              tx_par_r  <= odd_parity(tx_data);
              timer_r   <= 8'd0;
              phase_r   <= 1'b0;
              hb_cnt_r  <= 3'd0;
              state_r   <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (wrap_s) begin
              // Six toggles bring phase_r back to 0 for the first data bit.
              if (hb_cnt_r == 3'd5) begin
                hb_cnt_r  <= 3'd0;
                bit_idx_r <= 4'd15;
                state_r   <= ST_DATA;
              end else begin
                hb_cnt_r <= hb_cnt_r + 3'd1;
              end
            end
          end
          ST_DATA: begin
            if (wrap_s && phase_r) begin
              if (bit_idx_r == 4'd0) begin
                state_r <= ST_PARITY;
              end else begin
                bit_idx_r <= bit_idx_r - 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (final_s) begin
              // The timer wraps to 0 and phase_r toggles back to 0 here, so
              // the next sync starts on the very next clock.
              hb_cnt_r <= 3'd0;
              if (hold_full_r) begin
                tx_word_r   <= hold_data_r;
                tx_cd_r     <= hold_cd_r;
                tx_par_r    <= hold_par_r;
                hold_full_r <= 1'b0;
                state_r     <= ST_SYNC;
              end else if (req_s) begin
                tx_word_r <= tx_data;
                tx_cd_r   <= tx_cd;
                tx_par_r  <= odd_parity(tx_data);
                state_r   <= ST_SYNC;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase

        if (to_hold_s) begin
          hold_data_r <= tx_data;
          hold_cd_r   <= tx_cd;
          hold_par_r  <= odd_parity(tx_data);
          hold_full_r <= 1'b1;
        end
      end
    end
  end

  assign do_p       = do_p_r;
  assign do_n       = do_n_r;
  assign tx_busy    = busy_r;
  assign tx_done    = done_r;
  assign tx_overrun = ovr_r;

endmodule
